spi_shift_core: RTL and testbench
=================================

SPI_SHIFT_CORE -- requirements
Module: spi_shift_core

Interface
REQ-001 SHALL provide ports in this order (name  direction  width  meaning):
- PCLK  in  1  system clock; all state changes on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- send_data  in  1  one-cycle transfer start request from the APB slave interface.
- mosi_data  in  8  byte to transmit.
- mstr  in  1  1 = master enabled; 0 = abort and hold idle.
- cpol  in  1  SCLK idle level.
- cpha  in  1  clock phase.
- lsbfe  in  1  1 = LSB first; 0 = MSB first.
- spiswai  in  1  stop clocks in wait mode.
- spi_mode  in  2  00 = run, 01 = wait, others = stop.
- spr  in  3  baud rate exponent.
- sppr  in  3  baud rate preselect.
- miso  in  1  serial data in.
- sclk  out  1  SPI clock.
- mosi  out  1  serial data out.
- ss  out  1  slave select, active low.
- tip  out  1  transfer in progress.
- receive_data  out  1  one-cycle pulse: received byte valid.
- miso_data  out  8  received byte.

REQ-002 Clock and reset SHALL be exactly as stated: one clock, PCLK; reset PRESET is asynchronous and active-high.

Function
REQ-003 Baud divisor SHALL be D = (sppr+1) * 2^(spr+1), which ranges from 2 to 2048.
- Half-period H = D/2 PCLK cycles.
- Counter SHALL be 11 bits wide.
REQ-004 Define enable as `mstr & (spi_mode==00 | (spi_mode==01 & !spiswai))`.
- When enable is 0 and mstr is 1, all counters and the FSM SHALL freeze, and outputs SHALL hold.
REQ-005 When mstr is 0, the FSM SHALL go to IDLE on the next edge:
- ss = 1, tip = 0, sclk = cpol.
- No receive_data pulse is generated.
REQ-006 FSM states SHALL be IDLE, LEAD, XFER, TRAIL and DONE.
REQ-007 IDLE -> LEAD SHALL occur on send_data = 1 while enable = 1.
- The same edge SHALL load the shift register from mosi_data and set ss = 0 and tip = 1.
- mosi SHALL present the first bit: bit 0 if lsbfe = 1, else bit 7.
REQ-008 LEAD SHALL last H cycles, then go to XFER.
REQ-009 In XFER, sclk SHALL toggle every H cycles, giving 16 edges (odd edges leading, even edges trailing), then go to TRAIL.
REQ-010 Bit timing SHALL depend on cpha:
- cpha = 0: sample miso on leading edges; shift the next bit onto mosi on trailing edges, except after the 8th bit.
- cpha = 1: shift the next bit onto mosi on leading edges, except the first (bit already presented); sample on trailing edges.
REQ-011 Received bits SHALL assemble in the same order as transmitted (lsbfe applies to both directions).
REQ-012 TRAIL SHALL last H cycles with sclk = cpol, then go to DONE.
REQ-013 DONE SHALL last exactly 1 cycle:
- receive_data = 1 and miso_data = assembled byte.
- ss = 1 and tip = 0 in the same cycle.
- Next state is IDLE.
REQ-014 send_data SHALL be ignored outside IDLE; there is no queuing.
REQ-015 If send_data and a mstr-low abort occur in the same cycle, the abort SHALL win.
REQ-016 Total latency from the send_data edge to the receive_data pulse SHALL be 18H + 1 cycles.
REQ-017 miso_data SHALL hold its value until the next DONE.
REQ-018 spr, sppr, cpol, cpha and lsbfe SHALL be sampled at the IDLE -> LEAD transition and held constant for the whole transfer.
REQ-019 In IDLE, sclk SHALL equal the live cpol and mosi SHALL equal 0.

Reset
REQ-020 PRESET = 1 SHALL immediately force the following values, including mid-transfer, with no receive_data pulse:
- FSM in IDLE.
- ss = 1, tip = 0, receive_data = 0.
- sclk = 0 until cpol is sampled; then sclk = cpol.
- mosi = 0, miso_data = 8'h00.
- All counters cleared.

Verification
REQ-021 Setup: sppr = 0, spr = 0, cpol = 0, cpha = 0, lsbfe = 0, mosi_data = 8'hA5, miso looped to mosi, pulse send_data.
- ss is low for 18 cycles.
- receive_data pulses at cycle 19 with miso_data = 8'hA5.
REQ-022 Setup: cpol = 1, cpha = 1, lsbfe = 1, mosi_data = 8'h3C, miso tied 1, sppr = 1, spr = 1.
- D = 8, H = 4.
- sclk idles high.
- mosi order is 0,0,1,1,1,1,0,0.
- miso_data = 8'hFF after 73 cycles.
REQ-023 Assert PRESET at XFER edge 5.
- ss = 1 and tip = 0 immediately.
- No receive_data pulse.
- miso_data = 8'h00.
REQ-024 Set spi_mode = 01 and spiswai = 1 mid-XFER for 10 cycles, then clear.
- sclk holds during the stall.
- Completion is delayed by exactly 10 cycles.
- Data is intact.
REQ-025 Pulse send_data again during XFER.
- The pulse is ignored.
- Exactly one receive_data pulse occurs.
REQ-026 Drop mstr to 0 in LEAD while send_data is pulsed.
- Next cycle: IDLE, ss = 1, no receive_data.

Source files
------------

// File: rtl/spi_shift_core.sv
// SPI master shift core: baud generation, SCLK/SS sequencing and byte shifting.
module spi_shift_core (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       send_data,
  input  logic [7:0] mosi_data,
  input  logic       mstr,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       lsbfe,
  input  logic       spiswai,
  input  logic [1:0] spi_mode,
  input  logic [2:0] spr,
  input  logic [2:0] sppr,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       ss,
  output logic       tip,
  output logic       receive_data,
  output logic [7:0] miso_data
);

  localparam int unsigned CNT_W  = 11;
  localparam int unsigned EDGE_W = 5;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_XFER,
    ST_TRAIL,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [BYTE_W-1:0]   tx_q, tx_d;
  logic [BYTE_W-1:0]   rx_q, rx_d;
  logic [BYTE_W-1:0]   miso_data_q, miso_data_d;
  logic [2:0]          spr_q, spr_d;
  logic [2:0]          sppr_q, sppr_d;
  logic                cpol_q, cpol_d;
  logic                cpha_q, cpha_d;
  logic                lsb_q, lsb_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                ss_q, ss_d;
  logic                tip_q, tip_d;
  logic                rd_q, rd_d;

  logic                enable_c;
  logic [CNT_W-1:0]    half_c;
  logic [CNT_W-1:0]    half_m1_c;
  logic                term_c;
  logic                lead_edge_c;
  logic                sample_c;
  logic                shift_c;

  // Half-period in PCLK cycles from the latched baud settings: (sppr+1) << spr.
  always_comb begin
    enable_c    = mstr & ((spi_mode == 2'b00) | ((spi_mode == 2'b01) & ~spiswai));
    half_c      = CNT_W'((CNT_W'(sppr_q) + CNT_W'(1)) << spr_q);
    half_m1_c   = half_c - CNT_W'(1);
    term_c      = (cnt_q == half_m1_c);
    lead_edge_c = ~edge_q[0];
    sample_c    = lead_edge_c ^ cpha_q;
    shift_c     = ~sample_c & (edge_q != EDGE_W'(0)) & (edge_q != EDGE_W'(15));
  end

  // Next-state and output logic; mstr low aborts, enable low freezes everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    miso_data_d = miso_data_q;
    spr_d       = spr_q;
    sppr_d      = sppr_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    lsb_d       = lsb_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    ss_d        = ss_q;
    tip_d       = tip_q;
    rd_d        = rd_q;

    if (!mstr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      edge_d  = '0;
      sclk_d  = cpol;
      mosi_d  = 1'b0;
      ss_d    = 1'b1;
      tip_d   = 1'b0;
      rd_d    = 1'b0;
    end else if (enable_c) begin
      case (state_q)
        ST_IDLE: begin
          sclk_d = cpol;
          mosi_d = 1'b0;
          ss_d   = 1'b1;
          tip_d  = 1'b0;
          rd_d   = 1'b0;
          if (send_data) begin
            state_d = ST_LEAD;
            cnt_d   = '0;
            edge_d  = '0;
            tx_d    = mosi_data;
            rx_d    = '0;
            spr_d   = spr;
            sppr_d  = sppr;
            cpol_d  = cpol;
            cpha_d  = cpha;
            lsb_d   = lsbfe;
            mosi_d  = lsbfe ? mosi_data[0] : mosi_data[7];
            ss_d    = 1'b0;
            tip_d   = 1'b1;
          end
        end
        ST_LEAD: begin
          if (term_c) begin
            state_d = ST_XFER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_XFER: begin
          if (term_c) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
            edge_d = edge_q + EDGE_W'(1);
            if (sample_c) begin
              rx_d = lsb_q ? {miso, rx_q[7:1]} : {rx_q[6:0], miso};
            end
            if (shift_c) begin
              tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
              mosi_d = lsb_q ? tx_q[1] : tx_q[6];
            end
            if (edge_q == EDGE_W'(15)) begin
              state_d = ST_TRAIL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_TRAIL: begin
          sclk_d = cpol_q;
          if (term_c) begin
            state_d     = ST_DONE;
            cnt_d       = '0;
            ss_d        = 1'b1;
            tip_d       = 1'b0;
            rd_d        = 1'b1;
            miso_data_d = rx_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          rd_d    = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      edge_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      miso_data_q <= '0;
      spr_q       <= '0;
      sppr_q      <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ss_q        <= 1'b1;
      tip_q       <= 1'b0;
      rd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edge_q      <= edge_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      miso_data_q <= miso_data_d;
      spr_q       <= spr_d;
      sppr_q      <= sppr_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      lsb_q       <= lsb_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      ss_q        <= ss_d;
      tip_q       <= tip_d;
      rd_q        <= rd_d;
    end
  end

  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign ss           = ss_q;
  assign tip          = tip_q;
  assign receive_data = rd_q;
  assign miso_data    = miso_data_q;

endmodule

// File: tb/tb_spi_shift_core.sv
// Bench for spi_shift_core: vector table of directed and random transfers plus reset/abort sequences.
module tb_spi_shift_core;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       send_data;
  logic [7:0] mosi_data;
  logic       mstr, cpol, cpha, lsbfe, spiswai;
  logic [1:0] spi_mode;
  logic [2:0] spr, sppr;
  logic       miso;
  logic       sclk, mosi, ss, tip, receive_data;
  logic [7:0] miso_data;
  logic [1:0] miso_mode;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  // Slave side: 0 = loopback, 1 = inverted loopback, 2 = tied high.
  assign miso = (miso_mode == 2'd0) ? mosi : (miso_mode == 2'd1) ? ~mosi : 1'b1;

  spi_shift_core dut (
    .PCLK(PCLK), .PRESET(PRESET), .send_data(send_data), .mosi_data(mosi_data),
    .mstr(mstr), .cpol(cpol), .cpha(cpha), .lsbfe(lsbfe), .spiswai(spiswai),
    .spi_mode(spi_mode), .spr(spr), .sppr(sppr), .miso(miso),
    .sclk(sclk), .mosi(mosi), .ss(ss), .tip(tip), .receive_data(receive_data),
    .miso_data(miso_data)
  );

  typedef struct {
    logic [2:0] sppr;
    logic [2:0] spr;
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [7:0] data;
    logic [1:0] mmode;
    int         stall_at;
    int         stall_len;
    int         resend_at;
    logic [7:0] exp_rx;
    logic [7:0] exp_seq;
    int         exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  function automatic int half_of(input int sp, input int sr);
    return ((sp + 1) * (2 ** (sr + 1))) / 2;
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

  function automatic vec_t mk(input int sp, input int sr, input logic cp, input logic ch,
                              input logic lf, input logic [7:0] d, input logic [1:0] mm,
                              input int sa, input int sl, input int ra);
    vec_t v;
    int   h;
    v.sppr = 3'(sp); v.spr = 3'(sr); v.cpol = cp; v.cpha = ch; v.lsbfe = lf;
    v.data = d; v.mmode = mm; v.stall_at = sa; v.stall_len = sl; v.resend_at = ra;
    h = half_of(sp, sr);
    v.exp_lat = 18 * h + 1 + sl;
    v.exp_seq = lf ? rev8(d) : d;
    v.exp_rx  = (mm == 2'd0) ? d : (mm == 2'd1) ? ~d : 8'hFF;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int h, budget, lat, ss_low, edges, last_edge, bad_gap, stall_tog, nrd, nbits;
    logic [7:0] seen;
    logic prev_sclk;
    h = half_of(int'(v.sppr), int'(v.spr));
    budget = v.exp_lat + 2 * h + 4;
    lat = 0; ss_low = 0; edges = 0; last_edge = 0; bad_gap = 0; stall_tog = 0; nrd = 0; nbits = 0;
    seen = '0;
    @(posedge PCLK); #1;
    sppr = v.sppr; spr = v.spr; cpol = v.cpol; cpha = v.cpha; lsbfe = v.lsbfe;
    mosi_data = v.data; miso_mode = v.mmode; mstr = 1'b1; spi_mode = 2'b00; spiswai = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk($sformatf("v%0d_sclk_idle", idx), 32'(sclk), 32'(v.cpol));
    chk($sformatf("v%0d_mosi_idle", idx), 32'(mosi), 32'd0);
    @(posedge PCLK); #1 send_data = 1'b1;
    @(posedge PCLK); #1 send_data = 1'b0;
    // Disturb the live settings: the transfer must use the values captured at start.
    mosi_data = ~v.data; lsbfe = ~v.lsbfe; cpha = ~v.cpha; spr = v.spr ^ 3'd1; sppr = v.sppr ^ 3'd2;
    prev_sclk = v.cpol;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge PCLK);
      if (ss == 1'b0) ss_low++;
      if (sclk != prev_sclk) begin
        edges++;
        if (v.stall_len == 0 && edges > 1 && (cyc - last_edge) != h) bad_gap++;
        if (v.stall_len > 0 && cyc > v.stall_at && cyc <= v.stall_at + v.stall_len) stall_tog++;
        last_edge = cyc;
        if ((edges % 2 == 1) != v.cpha) begin
          seen = {seen[6:0], mosi};
          nbits++;
        end
      end
      prev_sclk = sclk;
      if (receive_data) begin
        nrd++;
        if (nrd == 1) begin
          lat = cyc;
          chk($sformatf("v%0d_miso_data", idx), 32'(miso_data), 32'(v.exp_rx));
          chk($sformatf("v%0d_ss_done", idx), 32'(ss), 32'd1);
          chk($sformatf("v%0d_tip_done", idx), 32'(tip), 32'd0);
        end
      end
      if (v.stall_len > 0 && cyc == v.stall_at) begin spi_mode = 2'b01; spiswai = 1'b1; end
      if (v.stall_len > 0 && cyc == v.stall_at + v.stall_len) begin spi_mode = 2'b00; spiswai = 1'b0; end
      if (cyc == v.resend_at) send_data = 1'b1;
      if (cyc == v.resend_at + 1) send_data = 1'b0;
    end
    send_data = 1'b0;
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_ss_low", idx), 32'(ss_low), 32'(18 * h + v.stall_len));
    chk($sformatf("v%0d_edges", idx), 32'(edges), 32'd16);
    chk($sformatf("v%0d_bad_gaps", idx), 32'(bad_gap), 32'd0);
    chk($sformatf("v%0d_stall_toggles", idx), 32'(stall_tog), 32'd0);
    chk($sformatf("v%0d_nbits", idx), 32'(nbits), 32'd8);
    chk($sformatf("v%0d_mosi_seq", idx), 32'(seen), 32'(v.exp_seq));
    chk($sformatf("v%0d_rd_pulses", idx), 32'(nrd), 32'd1);
    chk($sformatf("v%0d_sclk_end", idx), 32'(sclk), 32'(v.cpol));
    chk($sformatf("v%0d_tip_end", idx), 32'(tip), 32'd0);
    chk($sformatf("v%0d_miso_hold", idx), 32'(miso_data), 32'(v.exp_rx));
  endtask

  initial begin
    int h, nrd, ss_low, tog, sa, sl, ra;
    logic prev_sclk;
    vec_t v;

    PRESET = 1'b1; send_data = 1'b0; mosi_data = 8'h00; mstr = 1'b1; cpol = 1'b1; cpha = 1'b0;
    lsbfe = 1'b0; spiswai = 1'b0; spi_mode = 2'b00; spr = 3'd0; sppr = 3'd0; miso_mode = 2'd0;

    // Reset values while reset is held.
    #1;
    chk("rst_ss", 32'(ss), 32'd1);
    chk("rst_tip", 32'(tip), 32'd0);
    chk("rst_rd", 32'(receive_data), 32'd0);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_miso_data", 32'(miso_data), 32'd0);
    @(negedge PCLK); PRESET = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("post_rst_sclk_cpol", 32'(sclk), 32'd1);
    cpol = 1'b0;

    // Directed rows, then randomized rows.
    vecs.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0, 8'hA5, 2'd0, 0, 0, -1));
    vecs.push_back(mk(1, 1, 1'b1, 1'b1, 1'b1, 8'h3C, 2'd2, 0, 0, -1));
    vecs.push_back(mk(0, 0, 1'b0, 1'b0, 1'b0, 8'h5A, 2'd1, 6, 10, -1));
    vecs.push_back(mk(2, 0, 1'b0, 1'b1, 1'b1, 8'hD2, 2'd0, 0, 0, 20));
    vecs[0].exp_lat = 19;  vecs[0].exp_rx = 8'hA5;
    vecs[1].exp_lat = 73;  vecs[1].exp_rx = 8'hFF; vecs[1].exp_seq = 8'b0011_1100;
    vecs[2].exp_lat = 29;  vecs[2].exp_rx = 8'hA5;
    vecs[3].exp_lat = 55;  vecs[3].exp_seq = 8'h4B;
    for (int i = 0; i < 10; i++) begin
      int sp, sr;
      sp = int'($urandom_range(0, 7));
      sr = int'($urandom_range(0, 2));
      h  = half_of(sp, sr);
      sl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0;
      sa = int'($urandom_range(2 * h + 2, 16 * h));
      ra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2 * h + 2, 16 * h)) : -1;
      vecs.push_back(mk(sp, sr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                        2'($urandom_range(0, 2)), sa, sl, ra));
    end
    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset asserted mid-transfer after the fifth SCLK edge.
    run_vec(100, vecs[0]);
    @(posedge PCLK); #1;
    sppr = 3'd0; spr = 3'd0; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; mosi_data = 8'h81; miso_mode = 2'd0;
    send_data = 1'b1;
    @(posedge PCLK); #1 send_data = 1'b0;
    tog = 0; prev_sclk = 1'b0;
    for (int c = 0; c < 40 && tog < 5; c++) begin
      @(negedge PCLK);
      if (sclk != prev_sclk) tog++;
      prev_sclk = sclk;
    end
    chk("rst_mid_reached_edge5", 32'(tog), 32'd5);
    #2 PRESET = 1'b1;
    #1;
    chk("rst_mid_ss", 32'(ss), 32'd1);
    chk("rst_mid_tip", 32'(tip), 32'd0);
    chk("rst_mid_rd", 32'(receive_data), 32'd0);
    chk("rst_mid_miso_data", 32'(miso_data), 32'd0);
    chk("rst_mid_mosi", 32'(mosi), 32'd0);
    @(negedge PCLK); PRESET = 1'b0;
    nrd = 0; ss_low = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge PCLK);
      if (receive_data) nrd++;
      if (!ss) ss_low++;
    end
    chk("rst_mid_no_rd", 32'(nrd), 32'd0);
    chk("rst_mid_ss_stays_high", 32'(ss_low), 32'd0);

    // mstr dropped in LEAD together with a send_data pulse: abort wins.
    @(posedge PCLK); #1;
    sppr = 3'd1; spr = 3'd0; mosi_data = 8'h77;
    send_data = 1'b1;
    @(posedge PCLK); #1 send_data = 1'b0;
    @(negedge PCLK);
    chk("abort_in_lead_ss", 32'(ss), 32'd0);
    mstr = 1'b0; send_data = 1'b1;
    @(negedge PCLK);
    chk("abort_ss", 32'(ss), 32'd1);
    chk("abort_tip", 32'(tip), 32'd0);
    chk("abort_rd", 32'(receive_data), 32'd0);
    chk("abort_sclk", 32'(sclk), 32'(cpol));
    mstr = 1'b1; send_data = 1'b0;
    nrd = 0; ss_low = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge PCLK);
      if (receive_data) nrd++;
      if (!ss) ss_low++;
    end
    chk("abort_no_rd", 32'(nrd), 32'd0);
    chk("abort_stays_idle", 32'(ss_low), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
